fprint_gated_pio: RTL and testbench



---
 rtl/fprint_gated_pio_pkg.sv | 12 +
 rtl/fprint_gated_pio_chan.sv | 37 +++
 rtl/fprint_gated_pio.sv | 95 +++++++++
 tb/tb_fprint_gated_pio.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/fprint_gated_pio_pkg.sv
// fprint_gated_pio_pkg: address map, CONTROL bit positions and size limits for fprint_gated_pio
package fprint_gated_pio_pkg;
  localparam int MAX_CHANNELS = 8;
  localparam int MAX_WIDTH = 32;
  typedef enum logic [1:0] {SEL_SHADOW, SEL_LIVE, SEL_CSR, SEL_IRQ} sel_e;
  localparam logic [2:0] OFS_STATUS = 3'd0;
  localparam logic [2:0] OFS_CONTROL = 3'd1;
  localparam logic [2:0] OFS_IRQ_STATUS = 3'd0;
  localparam logic [2:0] OFS_IRQ_ENABLE = 3'd1;
  localparam int CTRL_FORCE_BIT = 8;
  localparam int STATUS_OVF_LSB = 8;
endpackage

// File: rtl/fprint_gated_pio_chan.sv
// fprint_gated_pio_chan: one channel's shadow/live pair, pending and overwrite flags, release edge detect
module fprint_gated_pio_chan #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rel,
  input  logic             mask,
  input  logic             frc,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] shadow,
  output logic [WIDTH-1:0] live,
  output logic             pending,
  output logic             overwrite,
  output logic             commit
);
  logic rel_q;
  assign commit = ((rel & ~rel_q & mask) | frc) & pending;
  // live captures the old shadow, so a write landing with a commit stays pending without counting as an overwrite
  always_ff @(posedge clk) begin
    if (reset) begin
      rel_q <= 1'b0;
      shadow <= '0;
      live <= '0;
      pending <= 1'b0;
      overwrite <= 1'b0;
    end else begin
      rel_q <= rel;
      if (wr) shadow <= wdata;
      if (commit) live <= shadow;
      pending <= wr | (pending & ~commit);
      overwrite <= (wr & pending & ~commit) | (overwrite & ~ovf_clr);
    end
  end
endmodule

// File: rtl/fprint_gated_pio.sv
// fprint_gated_pio: release-gated multi-channel Avalon-MM PIO; commit interrupt built with FPRINT_GATED_PIO_IRQ_EN
module fprint_gated_pio
  import fprint_gated_pio_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CHANNELS = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [4:0]                address,
  input  logic                      chipselect,
  input  logic                      write_n,
  input  logic [31:0]               writedata,
  output logic [31:0]               readdata,
  input  logic [CHANNELS-1:0]       io_release,
  output logic [CHANNELS*WIDTH-1:0] out_port,
  output logic                      irq
);
  sel_e sel;
  logic [2:0] ch;
  logic we, wr_csr, frc;
  logic [7:0] mask, pend, ovf, commit;
  logic [31:0] shadow_rd [MAX_CHANNELS];
  logic [31:0] live_rd [MAX_CHANNELS];
  logic [31:0] irq_rd;
  logic unused_ok;
  assign sel = sel_e'(address[4:3]);
  assign ch = address[2:0];
  assign we = chipselect & ~write_n;
  assign wr_csr = we & (sel == SEL_CSR);
  assign frc = wr_csr & (ch == OFS_CONTROL) & writedata[CTRL_FORCE_BIT];
  always_ff @(posedge clk) begin
    if (reset) mask <= 8'hff;
    else if (wr_csr && ch == OFS_CONTROL) mask <= writedata[7:0];
  end
  // unimplemented channel slots read as zero so the read mux indexes a full-size table
  for (genvar i = 0; i < MAX_CHANNELS; i++) begin : g_ch
    if (i < CHANNELS) begin : g_on
      logic [WIDTH-1:0] sh, lv;
      fprint_gated_pio_chan #(.WIDTH(WIDTH)) u_chan (
        .clk       (clk),
        .reset     (reset),
        .wr        (we && sel == SEL_SHADOW && ch == 3'(i)),
        .wdata     (writedata[WIDTH-1:0]),
        .rel       (io_release[i]),
        .mask      (mask[i]),
        .frc       (frc),
        .ovf_clr   (wr_csr && ch == OFS_STATUS && writedata[STATUS_OVF_LSB+i]),
        .shadow    (sh),
        .live      (lv),
        .pending   (pend[i]),
        .overwrite (ovf[i]),
        .commit    (commit[i])
      );
      assign shadow_rd[i] = 32'(sh);
      assign live_rd[i] = 32'(lv);
      assign out_port[i*WIDTH +: WIDTH] = lv;
    end else begin : g_off
      assign shadow_rd[i] = '0;
      assign live_rd[i] = '0;
      assign pend[i] = 1'b0;
      assign ovf[i] = 1'b0;
      assign commit[i] = 1'b0;
    end
  end
`ifdef FPRINT_GATED_PIO_IRQ_EN
  logic [7:0] irq_stat, irq_en;
  logic irq_wr;
  assign irq_wr = we & (sel == SEL_IRQ);
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_stat <= '0;
      irq_en <= '0;
      irq <= 1'b0;
    end else begin
      irq_stat <= commit | (irq_stat & ~((irq_wr && ch == OFS_IRQ_STATUS) ? writedata[7:0] : 8'h0));
      if (irq_wr && ch == OFS_IRQ_ENABLE) irq_en <= writedata[7:0];
      irq <= |(irq_stat & irq_en);
    end
  end
  assign irq_rd = ch == OFS_IRQ_STATUS ? {24'h0, irq_stat} : ch == OFS_IRQ_ENABLE ? {24'h0, irq_en} : '0;
  assign unused_ok = ^writedata[31:16];
`else
  assign irq = 1'b0;
  assign irq_rd = '0;
  assign unused_ok = ^{writedata[31:16], commit};
`endif
  always_comb begin
    readdata = sel == SEL_SHADOW ? shadow_rd[ch] :
               sel == SEL_LIVE   ? live_rd[ch] :
               sel == SEL_CSR    ? (ch == OFS_STATUS ? {16'h0, ovf, pend} :
                                    ch == OFS_CONTROL ? {24'h0, mask} : '0) :
               irq_rd;
  end
endmodule

// File: tb/tb_fprint_gated_pio.sv
// tb_fprint_gated_pio: directed test-plan sequence plus random traffic, scoreboarded against a register-level model
module tb_fprint_gated_pio;
  localparam int W = 4;
  localparam int CH = 2;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [4:0] address = '0;
  logic chipselect = 1'b0;
  logic write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [CH-1:0] io_release = '0;
  logic [CH*W-1:0] out_port;
  logic irq;
  int checks = 0;
  int failures = 0;
  logic [CH*W:0] q_out [$];
  logic [31:0] q_rd [$];
  bit rd_act = 1'b0;
  logic [CH-1:0] rel_now = '0;
  logic [W-1:0] m_sh [CH];
  logic [W-1:0] m_lv [CH];
  bit m_pd [CH];
  bit m_ov [CH];
  logic [7:0] m_mask, m_ist, m_ien;
  logic [CH-1:0] m_relp;
  bit m_irq;

  always #5 clk = ~clk;

  fprint_gated_pio #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(readdata), .io_release(io_release), .out_port(out_port), .irq(irq)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    int s = int'(a[4:3]);
    int c = int'(a[2:0]);
    logic [31:0] v = '0;
    if (s == 0 && c < CH) v = 32'(m_sh[c]);
    if (s == 1 && c < CH) v = 32'(m_lv[c]);
    if (s == 2 && c == 0) for (int k = 0; k < CH; k++) begin v[k] = m_pd[k]; v[8+k] = m_ov[k]; end
    if (s == 2 && c == 1) v = {24'h0, m_mask};
`ifdef FPRINT_GATED_PIO_IRQ_EN
    if (s == 3 && c == 0) v = {24'h0, m_ist};
    if (s == 3 && c == 1) v = {24'h0, m_ien};
`endif
    return v;
  endfunction

  function automatic logic [CH*W:0] model_out();
    logic [CH*W:0] e = '0;
    for (int k = 0; k < CH; k++) e[k*W +: W] = m_lv[k];
    e[CH*W] = m_irq;
    return e;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < CH; k++) begin m_sh[k] = '0; m_lv[k] = '0; m_pd[k] = 0; m_ov[k] = 0; end
    m_mask = 8'hff; m_ist = '0; m_ien = '0; m_relp = '0; m_irq = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; rel_now = '0; io_release = '0; rd_act = 1'b0;
    model_reset();
    q_out.push_back(model_out());
  endtask

  task automatic step(input bit w, input bit cs, input logic [4:0] a, input logic [31:0] d);
    bit we, frc, cm, swr;
    int s, c;
    logic [7:0] cmv;
    bit nirq;
    @(negedge clk);
    reset = 1'b0; chipselect = cs; write_n = ~w; address = a; writedata = d; io_release = rel_now;
    rd_act = cs && !w;
    if (rd_act) q_rd.push_back(model_read(a));
    we = cs && w; s = int'(a[4:3]); c = int'(a[2:0]);
    frc = we && s == 2 && c == 1 && d[8];
    nirq = |(m_ist & m_ien);
    cmv = '0;
    for (int k = 0; k < CH; k++) begin
      cm = ((rel_now[k] && !m_relp[k] && m_mask[k]) || frc) && m_pd[k];
      swr = we && s == 0 && c == k;
      cmv[k] = cm;
      if (cm) m_lv[k] = m_sh[k];
      if (swr && m_pd[k] && !cm) m_ov[k] = 1;
      else if (we && s == 2 && c == 0 && d[8+k]) m_ov[k] = 0;
      m_pd[k] = swr ? 1'b1 : cm ? 1'b0 : m_pd[k];
      if (swr) m_sh[k] = d[W-1:0];
    end
    if (we && s == 2 && c == 1) m_mask = d[7:0];
`ifdef FPRINT_GATED_PIO_IRQ_EN
    if (we && s == 3 && c == 0) m_ist &= ~d[7:0];
    m_ist |= cmv;
    if (we && s == 3 && c == 1) m_ien = d[7:0];
    m_irq = nirq;
`endif
    m_relp = rel_now;
    q_out.push_back(model_out());
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d); step(1, 1, a, d); endtask
  task automatic rd(input logic [4:0] a); step(0, 1, a, '0); endtask
  task automatic idle(); step(0, 0, '0, '0); endtask
  task automatic pulse0(); rel_now[0] = 1'b1; idle(); rel_now[0] = 1'b0; idle(); endtask

  initial begin : out_mon
    logic [CH*W:0] e;
    forever begin
      @(posedge clk); #1;
      if (q_out.size() > 0) begin
        e = q_out.pop_front();
        chk("out_port", 32'(out_port), 32'(e[CH*W-1:0]));
        chk("irq", 32'(irq), 32'(e[CH*W]));
      end
    end
  end

  initial begin : rd_mon
    forever begin
      @(negedge clk); #1;
      if (rd_act) begin
        if (q_rd.size() > 0) chk("readdata", readdata, q_rd.pop_front());
        else chk("rd_queue_empty", 32'd1, 32'd0);
      end
    end
  end

  initial begin
    int k;
    logic [4:0] a;
    model_reset();
    do_reset(); do_reset();
    rd(5'd0); rd(5'd16); rd(5'd17); rd(5'd24); rd(5'd8);
    wr(5'd0, 32'ha); rd(5'd16); pulse0(); rd(5'd16); rd(5'd8);
    rel_now[1] = 1'b1; idle(); wr(5'd1, 32'h5); idle(); rd(5'd9); rd(5'd16);
    rel_now[1] = 1'b0; idle(); rel_now[1] = 1'b1; idle(); idle(); rd(5'd9); rel_now[1] = 1'b0; idle();
    wr(5'd0, 32'h3); wr(5'd0, 32'h6); rd(5'd16); pulse0(); rd(5'd16); rd(5'd8); wr(5'd16, 32'h100); rd(5'd16);
    wr(5'd17, 32'h2); rd(5'd17); wr(5'd0, 32'h9); pulse0(); rd(5'd8); wr(5'd17, 32'h102); rd(5'd8); rd(5'd17); wr(5'd17, 32'hff);
    wr(5'd0, 32'h4); rel_now[0] = 1'b1; wr(5'd0, 32'hc); rd(5'd8); rd(5'd0); rd(5'd16); rel_now[0] = 1'b0; idle();
    wr(5'd25, 32'h1); wr(5'd0, 32'h7); pulse0(); idle(); rd(5'd24); wr(5'd24, 32'h1); idle(); idle();
    wr(5'd0, 32'h2); wr(5'd1, 32'h3); pulse0(); do_reset(); rd(5'd16); rd(5'd0); rd(5'd8); rd(5'd17);
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < CH; b++) if ($urandom_range(0, 2) == 0) rel_now[b] = ~rel_now[b];
      k = $urandom_range(0, 9);
      a = 5'($urandom);
      if ($urandom_range(0, 1) == 1) a = {4'b0, 1'($urandom)};
      if ($urandom_range(0, 199) == 0) do_reset();
      else if (k < 4) wr(a, $urandom);
      else if (k < 8) rd(5'($urandom));
      else idle();
    end
    repeat (3) idle();
    for (int n = 0; n < 10 && (q_out.size() > 0 || q_rd.size() > 0); n++) @(posedge clk);
    #2;
    chk("queues_drained", 32'(q_out.size() + q_rd.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
